// File: rtl/ex_branch.sv
// Branch execution unit: takes one ready entry from the branch station,
// resolves it, and raises a held redirect to fetch for taken branches.
module ex_branch #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4,
  parameter logic [TAG_W-1:0] UNLOCKED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rs_busy,
  input  logic [ADDR_W-1:0] rs_pc,
  input  logic [WORD_W-1:0] rs_offset,
  input  logic [OP_W-1:0]   rs_op,
  input  logic [TAG_W-1:0]  rs_tagx,
  input  logic [TAG_W-1:0]  rs_tagy,
  input  logic [WORD_W-1:0] rs_datax,
  input  logic [WORD_W-1:0] rs_datay,
  output logic              busy_branch,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ack,
  output logic              done,
  output logic              taken
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    REDIR
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                rv_q, rv_d;
  logic [ADDR_W-1:0]   rpc_q, rpc_d;
  logic                done_q, done_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic [WORD_W-1:0]   x_q, x_d;
  logic [WORD_W-1:0]   y_q, y_d;

  logic                ready;
  logic                cond;
  logic [ADDR_W-1:0]   target;

  assign ready = rs_busy
    && (rs_tagx == UNLOCKED)
    && (rs_tagy == UNLOCKED);

  assign target = pc_q + ADDR_W'(off_q);

  always_comb begin
    cond = 1'b0;
    case (f3_q)
      3'b000: cond = (x_q == y_q);
      3'b001: cond = (x_q != y_q);
      3'b100: cond = ($signed(x_q) < $signed(y_q));
      3'b101: cond = ($signed(x_q) >= $signed(y_q));
      3'b110: cond = (x_q < y_q);
      3'b111: cond = (x_q >= y_q);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = rs_busy;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    done_d  = 1'b0;
    taken_d = taken_q;
    pc_d    = pc_q;
    off_d   = off_q;
    f3_d    = f3_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          busy_d  = 1'b0;
          pc_d    = rs_pc;
          off_d   = rs_offset;
          f3_d    = rs_op[2:0];
          x_d     = rs_datax;
          y_d     = rs_datay;
          state_d = EXEC;
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        taken_d = cond;
        if (cond) begin
          rv_d    = 1'b1;
          rpc_d   = target;
          state_d = REDIR;
        end else begin
          state_d = IDLE;
        end
      end
      REDIR: begin
        if (redirect_ack) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy low freezes everything, including a pending done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      pc_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign busy_branch    = busy_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign done           = done_q;
  assign taken          = taken_q;

endmodule

// File: doc/ex_branch.md
Name: ex_branch

Overview:
- Branch execution unit. Consumer end of the branch reservation-station interface.
- Watches the station's held entry. Accepts it once both operand tags are unlocked, then evaluates the conditional branch.
- Frees the station via busy_branch and drives a held redirect request to fetch until fetch acknowledges.
- Static predict-not-taken: only taken branches redirect; every resolved branch raises a one-cycle done pulse.

Parameters:
- ADDR_W, 32, pc/target width
- WORD_W, 32, operand/offset width
- OP_W, 6, op field width; low 3 bits carry funct3
- TAG_W, 4, register tag width
- UNLOCKED, 4'b0000, tag value meaning operand data valid

Ports:
- clk  in  1  clock, posedge
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes every register
- rs_busy  in  1  station holds a valid entry
- rs_pc  in  ADDR_W  entry pc
- rs_offset  in  WORD_W  sign-extended branch offset
- rs_op  in  OP_W  branch op
- rs_tagx, rs_tagy  in  TAG_W  operand tags
- rs_datax, rs_datay  in  WORD_W  operand data
- busy_branch  out  1  registered; 1 = station keeps its entry, 0 = entry consumed/free
- redirect_valid  out  1  taken-branch redirect request, held until acked
- redirect_pc  out  ADDR_W  redirect target
- redirect_ack  in  1  fetch accepted redirect
- done  out  1  one-cycle pulse per resolved branch
- taken  out  1  outcome of last resolved branch, valid with done

Behaviour:
- Reset: all outputs 0, redirect_pc=0, state IDLE. Highest priority over rdy and all inputs. A reset mid-EXEC or mid-REDIRECT drops the branch with no done or redirect.
- rdy=0: all state and outputs hold; done does not re-pulse.
- Ready condition: rs_busy && rs_tagx==UNLOCKED && rs_tagy==UNLOCKED.
- IDLE:
  - busy_branch <= rs_busy.
  - If ready: latch pc, offset, funct3=rs_op[2:0], datax, datay; busy_branch <= 0; go to EXEC.
  - Not ready: stay, busy_branch <= rs_busy.
- EXEC, one cycle:
  - Compare by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011 resolve not-taken.
  - target = pc + offset, truncated mod 2^ADDR_W (wrap allowed, no flag).
  - done <= 1; taken <= result.
  - Taken: redirect_valid <= 1, redirect_pc <= target, go to REDIRECT. Not taken: go to IDLE.
  - busy_branch <= rs_busy. The station may have a new entry already; it is not accepted this cycle.
- REDIRECT:
  - Hold redirect_valid and redirect_pc stable until a cycle with redirect_ack=1. Next edge: redirect_valid <= 0, go to IDLE.
  - No new entry accepted while in REDIRECT; busy_branch tracks rs_busy.
  - redirect_ack while redirect_valid=0 is ignored.
- done: exactly one cycle (the edge after EXEC), then 0.
- Latency: ready observed at edge N; busy_branch=0 after N; done/redirect_valid=1 after N+1.
- Throughput:
  - Not-taken: at most one branch per 2 cycles.
  - Taken: at least 3 cycles (ack in the first REDIRECT cycle).
- Tags change while waiting in IDLE: re-evaluated every cycle; no latch until both unlocked.

Test Plan:
- Reset: assert rst 2 cycles with rs_busy=1 and ready -> busy_branch=0, redirect_valid=0, done=0, redirect_pc=0. Release -> accept on first edge.
- BEQ taken, pc=0x100, offset=0x20, x=y=5, tags unlocked, ack on first REDIRECT cycle:
  - busy_branch=0 next cycle.
  - Following cycle: done=1, taken=1, redirect_valid=1, redirect_pc=0x120.
  - redirect_valid drops the cycle after ack.
- BLT vs BLTU, x=0xFFFFFFFF, y=1, offset=8:
  - BLT -> taken, target pc+8.
  - BLTU -> not-taken: done=1, taken=0, no redirect, back to IDLE.
- Operand wait: tagx=3 for 4 cycles, then UNLOCKED with datax=7, y=7, BNE -> no accept while locked (busy_branch=1). Accept after unlock; taken=0.
- Redirect hold: taken BGE, redirect_ack low 5 cycles -> redirect_valid and redirect_pc stable 5 cycles. Second ready entry is not accepted until the cycle after the ack edge.
- Wrap, rdy, mid-op reset:
  - pc=0xFFFFFFF0, offset=0x20 -> redirect_pc=0x00000010.
  - rdy=0 in EXEC for 3 cycles -> state frozen, single done pulse afterwards.
  - rst during REDIRECT -> redirect_valid=0 next cycle, no done.
